// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register, word-addressed data memory, MEM/WB register.
// Loads read the memory combinationally from the EX/MEM address; stores commit at the end of the MEM cycle.
module mem_stage #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Aluout,
   input  logic        zeroAluout,
   input  logic [31:0] incadded,
   input  logic [4:0]  Muxout,
   input  logic [31:0] Read_out2,
   input  logic        RegWrite,
   input  logic        MemtoReg,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        Branch,
   input  logic        stall,
   input  logic        flush,
   output logic        PCSrc,
   output logic [31:0] branch_target,
   output logic        wb_RegWrite,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_MemtoReg,
   output logic        misalign_err
);

   localparam int AW = $clog2(DEPTH);

   // EX/MEM register
   logic [31:0] ex_aluout_reg;
   logic        ex_zero_reg;
   logic [31:0] ex_incadded_reg;
   logic [4:0]  ex_rd_reg;
   logic [31:0] ex_store_data_reg;
   logic        ex_reg_write_reg;
   logic        ex_mem_to_reg_reg;
   logic        ex_mem_read_reg;
   logic        ex_mem_write_reg;
   logic        ex_branch_reg;

   // MEM/WB register
   logic        wb_reg_write_reg;
   logic [4:0]  wb_rd_reg;
   logic [31:0] wb_data_reg;
   logic        wb_mem_to_reg_reg;
   logic        misalign_err_reg;

   logic [31:0] mem_reg [DEPTH];

   logic [AW-1:0] word_idx;
   logic          misaligned;
   logic          mem_access;
   logic          mem_we;
   logic [31:0]   load_data;
   logic [31:0]   wb_data_next;

   // Flush wins over stall: the incoming op still enters, but with all control bits dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_aluout_reg     <= '0;
         ex_zero_reg       <= 1'b0;
         ex_incadded_reg   <= '0;
         ex_rd_reg         <= '0;
         ex_store_data_reg <= '0;
         ex_reg_write_reg  <= 1'b0;
         ex_mem_to_reg_reg <= 1'b0;
         ex_mem_read_reg   <= 1'b0;
         ex_mem_write_reg  <= 1'b0;
         ex_branch_reg     <= 1'b0;
      end else if (flush || !stall) begin
         ex_aluout_reg     <= Aluout;
         ex_zero_reg       <= zeroAluout;
         ex_incadded_reg   <= incadded;
         ex_rd_reg         <= Muxout;
         ex_store_data_reg <= Read_out2;
         ex_reg_write_reg  <= RegWrite & ~flush;
         ex_mem_to_reg_reg <= MemtoReg & ~flush;
         ex_mem_read_reg   <= MemRead  & ~flush;
         ex_mem_write_reg  <= MemWrite & ~flush;
         ex_branch_reg     <= Branch   & ~flush;
      end
   end

   assign word_idx   = ex_aluout_reg[AW+1:2];
   assign misaligned = (ex_aluout_reg[1:0] != 2'b00);
   assign mem_access = ex_mem_read_reg | ex_mem_write_reg;
   assign mem_we     = ex_mem_write_reg & ~stall & ~misaligned;

   // Contents survive reset; a pending store is dropped because reset clears ex_mem_write_reg.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_reg[word_idx] <= ex_store_data_reg;
      end
   end

   always_comb begin
      load_data    = misaligned ? 32'd0 : mem_reg[word_idx];
      wb_data_next = ex_mem_to_reg_reg ? load_data : ex_aluout_reg;
   end

   // A stall turns the MEM/WB slot into a bubble while EX/MEM holds its op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_reg_write_reg  <= 1'b0;
         wb_rd_reg         <= '0;
         wb_data_reg       <= '0;
         wb_mem_to_reg_reg <= 1'b0;
         misalign_err_reg  <= 1'b0;
      end else begin
         if (stall) begin
            wb_reg_write_reg  <= 1'b0;
            wb_rd_reg         <= '0;
            wb_data_reg       <= '0;
            wb_mem_to_reg_reg <= 1'b0;
         end else begin
            wb_reg_write_reg  <= ex_reg_write_reg;
            wb_rd_reg         <= ex_rd_reg;
            wb_data_reg       <= wb_data_next;
            wb_mem_to_reg_reg <= ex_mem_to_reg_reg;
         end
         if (!stall && mem_access && misaligned) begin
            misalign_err_reg <= 1'b1;
         end
      end
   end

   assign PCSrc         = ex_branch_reg & ex_zero_reg;
   assign branch_target = ex_incadded_reg;
   assign wb_RegWrite   = wb_reg_write_reg;
   assign wb_rd         = wb_rd_reg;
   assign wb_data       = wb_data_reg;
   assign wb_MemtoReg   = wb_mem_to_reg_reg;
   assign misalign_err  = misalign_err_reg;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit data-memory words; power of two, 4..256.
REQ-002 clk  in  1  rising-edge clock; one clock domain only.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 Aluout  in  32  EXE ALU result; memory byte address or writeback value.
REQ-005 zeroAluout  in  1  EXE ALU zero flag.
REQ-006 incadded  in  32  EXE branch target.
REQ-007 Muxout  in  5  EXE destination register.
REQ-008 Read_out2  in  32  store data.
REQ-009 RegWrite, MemtoReg, MemRead, MemWrite, Branch  in  1 each  EXE-stage control bits.
REQ-010 stall  in  1  freezes the EX/MEM register and inserts a bubble into MEM/WB.
REQ-011 flush  in  1  replaces the incoming EXE op with a bubble.
REQ-012 PCSrc  out  1  branch taken, driven from the EX/MEM register.
REQ-013 branch_target  out  32  EX/MEM copy of incadded.
REQ-014 wb_RegWrite  out  1  writeback enable.
REQ-015 wb_rd  out  5  writeback register.
REQ-016 wb_data  out  32  writeback value: memory data if wb_MemtoReg, else ALU data.
REQ-017 wb_MemtoReg  out  1  registered MemtoReg.
REQ-018 misalign_err  out  1  sticky flag for a misaligned memory access.

Function
REQ-019 The EX/MEM register shall capture all EXE inputs on each rising clk when stall=0.
REQ-020 When flush=1, the EX/MEM register shall capture RegWrite=MemRead=MemWrite=Branch=MemtoReg=0; flush overrides stall.
REQ-021 When stall=1 and flush=0, the EX/MEM register shall hold its contents.
REQ-022 PCSrc shall equal ex_Branch AND ex_zero, combinational from the EX/MEM register; it is asserted in cycle N+1 for an op presented in cycle N.
REQ-023 The memory word index shall be ex_Aluout[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-024 A store shall write memory on the rising edge that ends cycle N+1 when ex_MemWrite=1, stall=0 and ex_Aluout[1:0]=0.
REQ-025 Load data shall be read combinationally from the EX/MEM address; a load from the address stored in the immediately preceding cycle shall return the new data.
REQ-026 The MEM/WB register shall capture on each rising clk; when stall=1 it shall capture a bubble (wb_RegWrite=0).
REQ-027 Total latency shall be 2 cycles: an op presented in cycle N appears on wb_* in cycle N+2.
REQ-028 A misaligned access (MemRead or MemWrite with ex_Aluout[1:0]≠0, stall=0) shall suppress the store, force the load data to 0, and set misalign_err; the writeback itself still occurs.
REQ-029 Simultaneous stall and a store in EX/MEM: no write during the stall cycles; exactly one write occurs in the first non-stall cycle.

Reset
REQ-030 rst_n=0 shall immediately clear both pipeline registers: all control bits 0, wb_rd=0, wb_data=0, branch_target=0, PCSrc=0, misalign_err=0.
REQ-031 Memory contents shall not be reset.
REQ-032 An op in flight when reset is asserted shall be discarded; a store pending in EX/MEM shall not be written.
REQ-033 misalign_err shall clear only on reset.

Verification
REQ-034 Store Read_out2=0xDEADBEEF at Aluout=0x10, then load Aluout=0x10 with MemtoReg=1 on the next cycle -> wb_data=0xDEADBEEF two cycles after the load.
REQ-035 Branch=1, zeroAluout=1, incadded=0x40 -> PCSrc=1 and branch_target=0x40 in the following cycle; with zeroAluout=0 -> PCSrc=0.
REQ-036 Store to 0x20 presented with stall=1 held for 3 cycles -> memory unchanged during the stall, one write after release, wb_RegWrite=0 while stalled.
REQ-037 flush=1 with RegWrite=1 and MemWrite=1 at 0x0 -> no memory write and wb_RegWrite=0 two cycles later.
REQ-038 Load at Aluout=0x13 -> wb_data=0, misalign_err=1 persisting; store at 0x22 -> memory unchanged.
REQ-039 rst_n pulsed low mid-cycle with a store pending -> outputs zero immediately, store dropped, other memory words retained.
